// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RISC controller: FSM stage codes,
// the 16 opcodes, writeback-mux and PC-mux selects, and PSW bit positions.
// No ports; imported by ctrl_decode and multicycle_ctrl_fsm.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } stage_t;

  localparam logic [3:0] OP_ALU0 = 4'h0;
  localparam logic [3:0] OP_ALU1 = 4'h1;
  localparam logic [3:0] OP_ALU2 = 4'h2;
  localparam logic [3:0] OP_ALU3 = 4'h3;
  localparam logic [3:0] OP_ALU4 = 4'h4;
  localparam logic [3:0] OP_ALU5 = 4'h5;
  localparam logic [3:0] OP_ALU6 = 4'h6;
  localparam logic [3:0] OP_CMP  = 4'h7;
  localparam logic [3:0] OP_LI   = 4'h8;
  localparam logic [3:0] OP_MOV  = 4'h9;
  localparam logic [3:0] OP_LD   = 4'hA;
  localparam logic [3:0] OP_ST   = 4'hB;
  localparam logic [3:0] OP_BZ   = 4'hC;
  localparam logic [3:0] OP_BN   = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_IMM = 2'd1;
  localparam logic [1:0] WB_RA  = 2'd2;
  localparam logic [1:0] WB_MEM = 2'd3;

  localparam logic PC_INC = 1'b0;
  localparam logic PC_TGT = 1'b1;

  // psw is packed {N,Z,C}
  localparam int PSW_N = 2;
  localparam int PSW_Z = 1;
  localparam int PSW_C = 0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier for the multicycle controller.
// Ports: opcode (4b) and psw {N,Z,C} in; one-hot-ish class flags out, plus
// br_taken which is set only for a conditional branch whose flag is true.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [2:0] psw,
  output logic       is_alu,
  output logic       is_cmp,
  output logic       is_li,
  output logic       is_mov,
  output logic       is_ld,
  output logic       is_st,
  output logic       is_br,
  output logic       is_jmp,
  output logic       is_hlt,
  output logic       br_taken
);

  logic is_bz;
  logic is_bn;

  // Carry is not consulted by any control decision.
  logic unused_c;
  assign unused_c = psw[PSW_C];

  assign is_alu = (opcode <= OP_ALU6);
  assign is_cmp = (opcode == OP_CMP);
  assign is_li  = (opcode == OP_LI);
  assign is_mov = (opcode == OP_MOV);
  assign is_ld  = (opcode == OP_LD);
  assign is_st  = (opcode == OP_ST);
  assign is_bz  = (opcode == OP_BZ);
  assign is_bn  = (opcode == OP_BN);
  assign is_br  = is_bz | is_bn;
  assign is_jmp = (opcode == OP_JMP);
  assign is_hlt = (opcode == OP_HLT);

  assign br_taken = (is_bz & psw[PSW_Z]) | (is_bn & psw[PSW_N]);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Stage FSM controller for the multicycle RISC datapath with memory wait
// states, single-step release and a retired-instruction counter.
// Ports: clk/Rst, ins/psw/mem_ready/step_en/step_go in; memory, datapath
// strobes/selects, done, stage and instr_cnt out.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int INS_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic [INS_W-1:0] ins,
  input  logic [2:0]       psw,
  input  logic             mem_ready,
  input  logic             step_en,
  input  logic             step_go,
  output logic             mem_req,
  output logic             mem_addr_sel,
  output logic             mem_we,
  output logic             ir_we,
  output logic             psw_we,
  output logic             rf_we,
  output logic             opb_sel,
  output logic [2:0]       alu_op,
  output logic [1:0]       wb_sel,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             done,
  output logic [2:0]       stage,
  output logic [CNT_W-1:0] instr_cnt
);

  stage_t           state_q, state_d;
  logic             pend_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       opcode;
  logic             released;
  logic             fetch_done;

  logic is_alu, is_cmp, is_li, is_mov, is_ld, is_st;
  logic is_br, is_jmp, is_hlt, br_taken;

  assign opcode = ins[INS_W-1 -: 4];

  // Operand fields are consumed by the datapath, not by the controller.
  logic unused_ins;
  assign unused_ins = ^ins[INS_W-5:0];

  ctrl_decode u_decode (
    .opcode   (opcode),
    .psw      (psw),
    .is_alu   (is_alu),
    .is_cmp   (is_cmp),
    .is_li    (is_li),
    .is_mov   (is_mov),
    .is_ld    (is_ld),
    .is_st    (is_st),
    .is_br    (is_br),
    .is_jmp   (is_jmp),
    .is_hlt   (is_hlt),
    .br_taken (br_taken)
  );

  // A fetch may start when free-running, or when a step pulse has been latched.
  assign released   = !step_en || pend_q;
  assign fetch_done = (state_q == ST_IF) && released && mem_ready;

  // State register
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) state_q <= ST_IF;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IF:   if (released && mem_ready) state_d = ST_ID;
      ST_ID:   state_d = is_hlt ? ST_HALT : ST_EX;
      ST_EX: begin
        if (is_alu || is_li || is_mov)  state_d = ST_WB;
        else if (is_ld || is_st)        state_d = ST_MEM;
        else                            state_d = ST_IF;
      end
      ST_MEM:  if (mem_ready) state_d = is_ld ? ST_WB : ST_IF;
      ST_WB:   state_d = ST_IF;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IF;
    endcase
  end

  // Output logic. Strobes are gated by Rst so an access in flight is dropped
  // the moment reset asserts, without waiting for a clock edge.
  always_comb begin
    mem_req      = 1'b0;
    mem_addr_sel = 1'b0;
    mem_we       = 1'b0;
    ir_we        = 1'b0;
    psw_we       = 1'b0;
    rf_we        = 1'b0;
    opb_sel      = 1'b0;
    wb_sel       = WB_ALU;
    pc_we        = 1'b0;
    pc_sel       = PC_INC;
    if (Rst) begin
      case (state_q)
        ST_IF: begin
          mem_req = released;
          ir_we   = released && mem_ready;
        end
        ST_EX: begin
          psw_we  = is_alu | is_cmp;
          opb_sel = is_ld | is_st;
          pc_we   = is_cmp | is_br | is_jmp;
          pc_sel  = (is_jmp | br_taken) ? PC_TGT : PC_INC;
        end
        ST_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = is_st;
          // Loads still owe a writeback; stores retire here.
          pc_we        = mem_ready && !is_ld;
        end
        ST_WB: begin
          rf_we = 1'b1;
          pc_we = 1'b1;
          if (is_li)       wb_sel = WB_IMM;
          else if (is_mov) wb_sel = WB_RA;
          else if (is_ld)  wb_sel = WB_MEM;
          else             wb_sel = WB_ALU;
        end
        default: ;
      endcase
    end
  end

  // A step pulse in the same cycle a fetch completes re-arms for the next
  // instruction, so the set takes priority over the clear.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst)            pend_q <= 1'b0;
    else if (step_go)    pend_q <= 1'b1;
    else if (fetch_done) pend_q <= 1'b0;
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst)       cnt_q <= '0;
    else if (pc_we) cnt_q <= cnt_q + 1'b1;
  end

  assign alu_op    = opcode[2:0];
  assign done      = Rst && (state_q == ST_HALT);
  assign stage     = state_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: directed vector table,
// hand-written step/reset/wrap sequences and a randomized phase-plan model.
// A second instance with a 4-bit counter shares all inputs to exercise wrap.
module tb_multicycle_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ins;
  logic [2:0]  psw;
  logic        mem_ready, step_en, step_go;

  logic        mem_req, mem_addr_sel, mem_we, ir_we, psw_we, rf_we, opb_sel;
  logic [2:0]  alu_op, stage;
  logic [1:0]  wb_sel;
  logic        pc_we, pc_sel, done;
  logic [15:0] instr_cnt;

  logic        mem_req4, mem_addr_sel4, mem_we4, ir_we4, psw_we4, rf_we4, opb_sel4;
  logic [2:0]  alu_op4, stage4;
  logic [1:0]  wb_sel4;
  logic        pc_we4, pc_sel4, done4;
  logic [3:0]  instr_cnt4;

  multicycle_ctrl_fsm #(.INS_W(16), .CNT_W(16)) u_dut (
    .clk(clk), .Rst(rst_n), .ins(ins), .psw(psw), .mem_ready(mem_ready),
    .step_en(step_en), .step_go(step_go), .mem_req(mem_req),
    .mem_addr_sel(mem_addr_sel), .mem_we(mem_we), .ir_we(ir_we),
    .psw_we(psw_we), .rf_we(rf_we), .opb_sel(opb_sel), .alu_op(alu_op),
    .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel), .done(done),
    .stage(stage), .instr_cnt(instr_cnt)
  );

  multicycle_ctrl_fsm #(.INS_W(16), .CNT_W(4)) u_dut4 (
    .clk(clk), .Rst(rst_n), .ins(ins), .psw(psw), .mem_ready(mem_ready),
    .step_en(step_en), .step_go(step_go), .mem_req(mem_req4),
    .mem_addr_sel(mem_addr_sel4), .mem_we(mem_we4), .ir_we(ir_we4),
    .psw_we(psw_we4), .rf_we(rf_we4), .opb_sel(opb_sel4), .alu_op(alu_op4),
    .wb_sel(wb_sel4), .pc_we(pc_we4), .pc_sel(pc_sel4), .done(done4),
    .stage(stage4), .instr_cnt(instr_cnt4)
  );

  always #5 clk = ~clk;

  // Strobe vector layout used by all expectations below.
  localparam logic [11:0] MREQ  = 12'h800;
  localparam logic [11:0] ASEL  = 12'h400;
  localparam logic [11:0] MWE   = 12'h200;
  localparam logic [11:0] IRWE  = 12'h100;
  localparam logic [11:0] PSWWE = 12'h080;
  localparam logic [11:0] RFWE  = 12'h040;
  localparam logic [11:0] OPB   = 12'h020;
  localparam logic [11:0] WB1   = 12'h008;
  localparam logic [11:0] WB2   = 12'h010;
  localparam logic [11:0] WB3   = 12'h018;
  localparam logic [11:0] PCWE  = 12'h004;
  localparam logic [11:0] PCSEL = 12'h002;
  localparam logic [11:0] DONE  = 12'h001;

  logic [11:0] act_out;
  assign act_out = {mem_req, mem_addr_sel, mem_we, ir_we, psw_we, rf_we,
                    opb_sel, wb_sel, pc_we, pc_sel, done};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic step);
    rst_n = 1'b0; step_en = step; step_go = 1'b0; mem_ready = 1'b0;
    ins = 16'h0000; psw = 3'b000;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  // One cycle with given step pulse / ready; accumulates retirements seen.
  task automatic cyc(input logic go, input logic rdy, inout int pcw);
    step_go = go; mem_ready = rdy;
    #4;
    if (pc_we) pcw++;
    next_cycle();
  endtask

  typedef struct {
    logic [15:0] ins;
    logic [2:0]  psw;
    logic        rdy;
    logic [2:0]  stg;
    logic [11:0] out;
  } row_t;

  row_t tbl[$];

  task automatic add(input logic [15:0] i, input logic [2:0] p, input logic r,
                     input logic [2:0] s, input logic [11:0] o);
    row_t rw;
    rw.ins = i; rw.psw = p; rw.rdy = r; rw.stg = s; rw.out = o;
    tbl.push_back(rw);
  endtask

  localparam byte PH_F = 1, PH_D = 2, PH_E = 3, PH_M = 4, PH_W = 5;

  initial begin
    int pcw;
    int seen_req;
    byte plan[$];
    logic [15:0] cur_ins;
    logic [2:0]  cur_psw;
    logic [3:0]  op;
    logic [2:0]  es;
    logic [11:0] eo;
    int mcnt;

    // ADD: IF, ID, EX, WB
    add(16'h1234, 3'b000, 1, 3'd0, MREQ | IRWE);
    add(16'h1234, 3'b000, 0, 3'd1, 12'h000);
    add(16'h1234, 3'b000, 0, 3'd2, PSWWE);
    add(16'h1234, 3'b000, 0, 3'd4, RFWE | PCWE);
    // CMP
    add(16'h7abc, 3'b111, 1, 3'd0, MREQ | IRWE);
    add(16'h7abc, 3'b111, 1, 3'd1, 12'h000);
    add(16'h7abc, 3'b111, 1, 3'd2, PSWWE | PCWE);
    // BZ taken (Z=1)
    add(16'hC010, 3'b010, 1, 3'd0, MREQ | IRWE);
    add(16'hC010, 3'b010, 1, 3'd1, 12'h000);
    add(16'hC010, 3'b010, 1, 3'd2, PCWE | PCSEL);
    // BZ not taken (N=1 only)
    add(16'hC010, 3'b101, 1, 3'd0, MREQ | IRWE);
    add(16'hC010, 3'b101, 1, 3'd1, 12'h000);
    add(16'hC010, 3'b101, 1, 3'd2, PCWE);
    // BN taken
    add(16'hD001, 3'b100, 1, 3'd0, MREQ | IRWE);
    add(16'hD001, 3'b100, 1, 3'd1, 12'h000);
    add(16'hD001, 3'b100, 1, 3'd2, PCWE | PCSEL);
    // JMP
    add(16'hE0FF, 3'b000, 1, 3'd0, MREQ | IRWE);
    add(16'hE0FF, 3'b000, 1, 3'd1, 12'h000);
    add(16'hE0FF, 3'b000, 1, 3'd2, PCWE | PCSEL);
    // LD with two wait cycles in MEM: WB at cycle 7
    add(16'hA123, 3'b000, 1, 3'd0, MREQ | IRWE);
    add(16'hA123, 3'b000, 1, 3'd1, 12'h000);
    add(16'hA123, 3'b000, 1, 3'd2, OPB);
    add(16'hA123, 3'b000, 0, 3'd3, MREQ | ASEL);
    add(16'hA123, 3'b000, 0, 3'd3, MREQ | ASEL);
    add(16'hA123, 3'b000, 1, 3'd3, MREQ | ASEL);
    add(16'hA123, 3'b000, 0, 3'd4, RFWE | PCWE | WB3);
    // ST with one wait cycle in IF
    add(16'hB456, 3'b000, 0, 3'd0, MREQ);
    add(16'hB456, 3'b000, 1, 3'd0, MREQ | IRWE);
    add(16'hB456, 3'b000, 1, 3'd1, 12'h000);
    add(16'hB456, 3'b000, 1, 3'd2, OPB);
    add(16'hB456, 3'b000, 1, 3'd3, MREQ | ASEL | MWE | PCWE);
    // LI
    add(16'h8077, 3'b000, 1, 3'd0, MREQ | IRWE);
    add(16'h8077, 3'b000, 1, 3'd1, 12'h000);
    add(16'h8077, 3'b000, 1, 3'd2, 12'h000);
    add(16'h8077, 3'b000, 1, 3'd4, RFWE | PCWE | WB1);
    // MOV
    add(16'h9012, 3'b000, 1, 3'd0, MREQ | IRWE);
    add(16'h9012, 3'b000, 1, 3'd1, 12'h000);
    add(16'h9012, 3'b000, 1, 3'd2, 12'h000);
    add(16'h9012, 3'b000, 1, 3'd4, RFWE | PCWE | WB2);
    // ALU op 6
    add(16'h6fff, 3'b011, 1, 3'd0, MREQ | IRWE);
    add(16'h6fff, 3'b011, 1, 3'd1, 12'h000);
    add(16'h6fff, 3'b011, 1, 3'd2, PSWWE);
    add(16'h6fff, 3'b011, 1, 3'd4, RFWE | PCWE);
    // HLT: done from cycle 3, no strobes
    add(16'hF000, 3'b000, 1, 3'd0, MREQ | IRWE);
    add(16'hF000, 3'b000, 1, 3'd1, 12'h000);
    add(16'hF000, 3'b000, 1, 3'd5, DONE);
    add(16'hF000, 3'b000, 1, 3'd5, DONE);
    add(16'h1000, 3'b111, 1, 3'd5, DONE);

    // Reset state, checked while reset is held (free-running mode).
    rst_n = 1'b0; step_en = 1'b0; step_go = 1'b0; mem_ready = 1'b1;
    ins = 16'h1000; psw = 3'b000;
    #3;
    check("reset_state", {stage, act_out, instr_cnt, instr_cnt4},
          {3'd0, 12'h000, 16'd0, 4'd0});

    // Directed vector table
    do_reset(1'b0);
    foreach (tbl[k]) begin
      ins = tbl[k].ins; psw = tbl[k].psw; mem_ready = tbl[k].rdy; step_go = 1'b0;
      #4;
      check($sformatf("vec%0d", k), {stage, act_out, alu_op},
            {tbl[k].stg, tbl[k].out, tbl[k].ins[14:12]});
      next_cycle();
    end
    check("vec_retired", {instr_cnt, instr_cnt4}, {16'd11, 4'd11});

    // Async reset out of HALT
    #2 rst_n = 1'b0;
    #1;
    check("halt_reset", {stage, act_out, instr_cnt}, {3'd0, 12'h000, 16'd0});
    next_cycle();

    // Single-step: no request without a pulse
    do_reset(1'b1);
    ins = 16'h7000; psw = 3'b000;
    seen_req = 0; pcw = 0;
    for (int i = 0; i < 20; i++) begin
      step_go = 1'b0; mem_ready = 1'b1;
      #4;
      if (mem_req) seen_req++;
      next_cycle();
    end
    check("step_idle", {32'(seen_req), 29'd0, stage}, {32'd0, 29'd0, 3'd0});

    pcw = 0;
    cyc(1'b1, 1'b1, pcw);
    for (int i = 0; i < 30; i++) cyc(1'b0, 1'b1, pcw);
    check("step_one", 64'(pcw), 64'd1);

    // Back-to-back pulses while memory is stalled collapse to one release
    pcw = 0;
    cyc(1'b1, 1'b0, pcw);
    cyc(1'b1, 1'b0, pcw);
    cyc(1'b0, 1'b0, pcw);
    cyc(1'b0, 1'b0, pcw);
    for (int i = 0; i < 30; i++) cyc(1'b0, 1'b1, pcw);
    check("step_collapse", 64'(pcw), 64'd1);

    // Pulse coinciding with fetch completion arms the next instruction
    pcw = 0;
    cyc(1'b1, 1'b1, pcw);
    cyc(1'b1, 1'b1, pcw);
    for (int i = 0; i < 30; i++) cyc(1'b0, 1'b1, pcw);
    check("step_set_wins", 64'(pcw), 64'd2);
    check("step_cnt", {instr_cnt, instr_cnt4}, {16'd4, 4'd4});

    // Reset during a MEM wait drops the request without a clock edge
    do_reset(1'b0);
    ins = 16'hA000; pcw = 0;
    cyc(1'b0, 1'b1, pcw);
    cyc(1'b0, 1'b1, pcw);
    cyc(1'b0, 1'b1, pcw);
    mem_ready = 1'b0;
    #4;
    check("mem_wait", {stage, act_out}, {3'd3, MREQ | ASEL});
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_mem", {stage, act_out}, {3'd0, 12'h000});
    next_cycle();

    // 16 CMPs: 4-bit counter wraps, 16-bit counter does not
    do_reset(1'b0);
    ins = 16'h7000; pcw = 0;
    for (int i = 0; i < 48; i++) cyc(1'b0, 1'b1, pcw);
    check("cnt_wrap", {instr_cnt, instr_cnt4}, {16'd16, 4'd0});

    // Randomized run against a phase-plan model
    do_reset(1'b0);
    mcnt = 0;
    cur_ins = 16'h0; cur_psw = 3'b0;
    for (int c = 0; c < 3000; c++) begin
      if (plan.size() == 0) begin
        op = 4'($urandom_range(0, 14));
        cur_ins = {op, 12'($urandom)};
        cur_psw = 3'($urandom);
        plan.push_back(PH_F); plan.push_back(PH_D); plan.push_back(PH_E);
        if (op == 4'hA) begin plan.push_back(PH_M); plan.push_back(PH_W); end
        else if (op == 4'hB) plan.push_back(PH_M);
        else if (op <= 4'h6 || op == 4'h8 || op == 4'h9) plan.push_back(PH_W);
      end
      op = cur_ins[15:12];
      ins = cur_ins; psw = cur_psw;
      mem_ready = ($urandom % 4) != 0;
      step_go = ($urandom % 8) == 0;
      es = 3'd0; eo = 12'h000;
      case (plan[0])
        PH_F: begin es = 3'd0; eo = MREQ | (mem_ready ? IRWE : 12'h000); end
        PH_D: es = 3'd1;
        PH_E: begin
          es = 3'd2;
          if (op <= 4'h6)                      eo = PSWWE;
          else if (op == 4'h7)                 eo = PSWWE | PCWE;
          else if (op == 4'hA || op == 4'hB)   eo = OPB;
          else if (op == 4'hC)                 eo = PCWE | (cur_psw[1] ? PCSEL : 12'h000);
          else if (op == 4'hD)                 eo = PCWE | (cur_psw[2] ? PCSEL : 12'h000);
          else if (op == 4'hE)                 eo = PCWE | PCSEL;
        end
        PH_M: begin
          es = 3'd3;
          eo = MREQ | ASEL;
          if (op == 4'hB) eo = eo | MWE | (mem_ready ? PCWE : 12'h000);
        end
        PH_W: begin
          es = 3'd4;
          eo = RFWE | PCWE;
          if (op == 4'h8)      eo = eo | WB1;
          else if (op == 4'h9) eo = eo | WB2;
          else if (op == 4'hA) eo = eo | WB3;
        end
        default: ;
      endcase
      #4;
      check($sformatf("rand%0d", c), {stage, act_out, alu_op, instr_cnt, instr_cnt4},
            {es, eo, cur_ins[14:12], 16'(mcnt), 4'(mcnt)});
      if ((eo & PCWE) != 12'h000) mcnt++;
      if (!((plan[0] == PH_F || plan[0] == PH_M) && !mem_ready)) void'(plan.pop_front());
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
